// File: rtl/vector_ram_stream_ctrl_if.sv
// Purpose: handshake and data bundle between vector_ram_stream_ctrl and its
//          command source, write/read streams and the vector RAM slave port.
// Latency: none (pure wiring).
// Backpressure: valid/ready on cmd, wr, rd, vr request and vr read-return channels.
// Ports (signals):
//   cmd_*  : command channel (valid/ready, write flag, element base, beat count)
//   wr_*   : write-data stream into the controller
//   rd_*   : read-data stream out of the controller, rd_last marks the final beat
//   vr_*   : vector RAM request (valid/ready/write/addr/wdata) and read return
// Modports: master = controller side, slave = environment (source/sink/RAM).
interface vector_ram_stream_ctrl_if #(
  parameter int PARALLELISM = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int LEN_WIDTH   = 16
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic                              cmd_write;
  logic [ADDR_WIDTH-1:0]             cmd_base;
  logic [LEN_WIDTH-1:0]              cmd_len;

  logic                              wr_valid;
  logic                              wr_ready;
  logic [PARALLELISM*DATA_WIDTH-1:0] wr_data;

  logic                              rd_valid;
  logic                              rd_ready;
  logic [PARALLELISM*DATA_WIDTH-1:0] rd_data;
  logic                              rd_last;

  logic                              vr_valid;
  logic                              vr_ready;
  logic                              vr_write;
  logic [PARALLELISM*ADDR_WIDTH-1:0] vr_addr;
  logic [PARALLELISM*DATA_WIDTH-1:0] vr_wdata;
  logic                              vr_rvalid;
  logic [PARALLELISM*DATA_WIDTH-1:0] vr_rdata;
  logic                              vr_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_base, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  vr_ready, vr_rvalid, vr_rdata,
    output cmd_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output vr_valid, vr_write, vr_addr, vr_wdata, vr_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_base, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output vr_ready, vr_rvalid, vr_rdata,
    input  cmd_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  vr_valid, vr_write, vr_addr, vr_wdata, vr_rready
  );
endinterface

// File: rtl/vector_ram_stream_ctrl.sv
// Purpose: sweeps a contiguous vector-RAM region in PARALLELISM-wide beats;
//          write commands forward the wr stream to the RAM, read commands issue
//          read beats and stream returned data out on rd.
// Latency: command accepted in 1 cycle, first RAM request the next cycle; write
//          data and read returns pass through combinationally; done pulses the
//          cycle after the last beat completes.
// Backpressure: wr_ready follows vr_ready, vr_rready follows rd_ready; read issue
//          stalls once MAX_OUTSTANDING beats are in flight.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : vector_ram_stream_ctrl_if.master (cmd, wr, rd and vr channels)
//   busy_o     : high whenever a command is being processed
//   done_o     : one-cycle pulse on command completion
module vector_ram_stream_ctrl #(
  parameter int PARALLELISM     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vector_ram_stream_ctrl_if.master  bus,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int LOG2P = $clog2(PARALLELISM);
  localparam int OFFW  = LEN_WIDTH + LOG2P;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  ret_cnt_q, ret_cnt_d;
  logic [OW-1:0]         outst_q, outst_d;

  logic [LEN_WIDTH-1:0]  last_idx;
  logic [OFFW-1:0]       beat_off;
  logic                  issue_en;
  logic                  issue_fire;
  logic                  ret_fire;

  assign last_idx = len_q - LEN_WIDTH'(1);

  // Element offset of lane 0 for the current beat; the final cast to
  // ADDR_WIDTH gives the silent modulo wrap of the address space.
  assign beat_off = OFFW'(issue_cnt_q) << LOG2P;

  always_comb begin
    for (int i = 0; i < PARALLELISM; i++) begin
      bus.vr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = base_q + ADDR_WIDTH'(beat_off) + ADDR_WIDTH'(i);
    end
  end

  // Data paths are plain pass-through; only the handshakes are gated by state.
  assign bus.vr_wdata = bus.wr_data;
  assign bus.rd_data  = bus.vr_rdata;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    outst_d     = outst_q;

    issue_en    = 1'b0;
    issue_fire  = 1'b0;
    ret_fire    = 1'b0;

    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.rd_last   = 1'b0;
    bus.vr_valid  = 1'b0;
    bus.vr_write  = 1'b0;
    bus.vr_rready = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_o        = 1'b0;
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          base_d      = bus.cmd_base;
          len_d       = bus.cmd_len;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          outst_d     = '0;
          if (bus.cmd_len == '0) begin
            state_d = S_DONE;
          end else if (bus.cmd_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_WRITE: begin
        bus.vr_valid = bus.wr_valid;
        bus.wr_ready = bus.vr_ready;
        bus.vr_write = 1'b1;
        if (bus.wr_valid && bus.vr_ready) begin
          issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
          if (issue_cnt_q == last_idx) begin
            state_d = S_DONE;
          end
        end
      end

      S_READ: begin
        // Issue is gated only by internal counters so vr_valid never
        // depends on vr_ready.
        issue_en      = (issue_cnt_q < len_q) && (outst_q < OW'(MAX_OUTSTANDING));
        issue_fire    = issue_en && bus.vr_ready;
        ret_fire      = bus.vr_rvalid && bus.rd_ready;
        bus.vr_valid  = issue_en;
        bus.rd_valid  = bus.vr_rvalid;
        bus.vr_rready = bus.rd_ready;
        bus.rd_last   = bus.vr_rvalid && (ret_cnt_q == last_idx);

        if (issue_fire) begin
          issue_cnt_d = issue_cnt_q + LEN_WIDTH'(1);
        end
        if (ret_fire) begin
          ret_cnt_d = ret_cnt_q + LEN_WIDTH'(1);
        end
        case ({issue_fire, ret_fire})
          2'b10:   outst_d = outst_q + OW'(1);
          2'b01:   outst_d = outst_q - OW'(1);
          default: outst_d = outst_q;
        endcase
        // The final return implies every beat was issued already.
        if (ret_fire && (ret_cnt_q == last_idx)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      outst_q     <= outst_d;
    end
  end

endmodule

// File: tb/tb_vector_ram_stream_ctrl.sv
// Purpose: directed bench for vector_ram_stream_ctrl with a RAM model, a
//          write-stream source and scoreboards for requests and read returns.
// Latency: RAM model returns read data one cycle after request acceptance.
// Backpressure: vr_ready / rd_ready / wr_valid optionally randomised or held.
module tb_vector_ram_stream_ctrl;
  localparam int P  = 4;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int MO = 8;
  localparam int BW = P * DW;

  typedef logic [BW-1:0]   beat_t;
  typedef logic [P*AW-1:0] addrv_t;
  typedef struct packed {
    logic   write;
    addrv_t addr;
    beat_t  wdata;
  } req_t;
  typedef struct packed {
    beat_t data;
    logic  last;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic done;

  vector_ram_stream_ctrl_if #(.PARALLELISM(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus_if ();

  vector_ram_stream_ctrl #(
    .PARALLELISM(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  req_t  exp_req[$];
  rsp_t  exp_rd[$];
  beat_t wr_q[$];
  beat_t resp_q[$];
  logic [DW-1:0] ram [int];
  logic [DW-1:0] ref_mem [int];

  bit    rand_vr = 0, rand_rd = 0, rand_wr = 0, rd_hold = 0;
  logic  ram_rvalid = 1'b0;
  logic  inj_rvalid = 1'b0;
  bit    pend_wpop = 0, pend_rpop = 0, pend_push = 0;
  beat_t pend_data;
  int    req_rd_cnt = 0, rd_beats = 0, done_cnt = 0, vr_valid_cnt = 0;
  int    outst = 0, max_outst = 0, last_wr_cyc = 0;
  addrv_t last_wr_addr = '0;
  req_t  mon_e;
  rsp_t  mon_r;
  beat_t mon_d;

  always_comb bus_if.vr_rvalid = ram_rvalid | inj_rvalid;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic addrv_t lane_addrs(input logic [AW-1:0] base, input int b);
    addrv_t v;
    for (int i = 0; i < P; i++) v[i*AW +: AW] = base + AW'(b * P) + AW'(i);
    return v;
  endfunction

  // Queue the expected traffic for a command, then offer it until accepted.
  task automatic send_cmd(input bit wr, input logic [AW-1:0] base, input int len);
    addrv_t a;
    beat_t  d;
    rsp_t   r;
    req_t   q;
    for (int b = 0; b < len; b++) begin
      a = lane_addrs(base, b);
      for (int i = 0; i < P; i++) begin
        if (wr) begin
          d[i*DW +: DW] = $urandom();
          ref_mem[int'(a[i*AW +: AW])] = d[i*DW +: DW];
        end else begin
          d[i*DW +: DW] = ref_mem[int'(a[i*AW +: AW])];
        end
      end
      if (wr) begin
        wr_q.push_back(d);
      end else begin
        r.data = d;
        r.last = (b == len - 1);
        exp_rd.push_back(r);
      end
      q.write = wr;
      q.addr  = a;
      q.wdata = wr ? d : '0;
      exp_req.push_back(q);
    end
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_base  = base;
    bus_if.cmd_len   = LW'(len);
    for (int i = 0; i < 200 && !bus_if.cmd_ready; i++) tick();
    check("cmd_ready_at_offer", bus_if.cmd_ready, 1'b1);
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit found = 0;
    dcyc = 0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        found = 1;
        dcyc  = cyc;
        break;
      end
      tick();
    end
    check("done_seen", found, 1'b1);
  endtask

  // Environment driver: applies handshakes seen at the previous negedge,
  // then drives the next cycle's RAM return, write stream and readies.
  initial begin
    bus_if.wr_valid = 1'b0;
    bus_if.wr_data  = '0;
    bus_if.vr_ready = 1'b0;
    bus_if.rd_ready = 1'b0;
    bus_if.vr_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_wpop && wr_q.size() != 0) void'(wr_q.pop_front());
      if (pend_rpop && resp_q.size() != 0) void'(resp_q.pop_front());
      if (pend_push) resp_q.push_back(pend_data);
      pend_wpop = 0;
      pend_rpop = 0;
      pend_push = 0;
      if (!rst_n) resp_q.delete();
      ram_rvalid      = (resp_q.size() != 0);
      bus_if.vr_rdata = (resp_q.size() != 0) ? resp_q[0] : '0;
      bus_if.wr_valid = (wr_q.size() != 0) && (!rand_wr || $urandom_range(0, 3) != 0);
      bus_if.wr_data  = (wr_q.size() != 0) ? wr_q[0] : '0;
      bus_if.vr_ready = !rand_vr || ($urandom_range(0, 3) != 0);
      bus_if.rd_ready = !rd_hold && (!rand_rd || $urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples settled signals mid-cycle, i.e. the handshakes that
  // complete at the coming posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      outst     = 0;
      pend_wpop = 0;
      pend_rpop = 0;
      pend_push = 0;
    end else begin
      if (bus_if.vr_valid) vr_valid_cnt++;
      if (done) done_cnt++;
      if (bus_if.vr_valid && bus_if.vr_ready) begin
        check("req_expected", exp_req.size() != 0, 1'b1);
        if (exp_req.size() != 0) begin
          mon_e = exp_req.pop_front();
          check("req_write", bus_if.vr_write, mon_e.write);
          check("req_addr", bus_if.vr_addr, mon_e.addr);
          if (mon_e.write) check("req_wdata", bus_if.vr_wdata, mon_e.wdata);
        end
        if (bus_if.vr_write) begin
          for (int i = 0; i < P; i++) ram[int'(bus_if.vr_addr[i*AW +: AW])] = bus_if.vr_wdata[i*DW +: DW];
          last_wr_addr = bus_if.vr_addr;
          last_wr_cyc  = cyc;
        end else begin
          for (int i = 0; i < P; i++) begin
            mon_d[i*DW +: DW] = ram.exists(int'(bus_if.vr_addr[i*AW +: AW])) ?
                                ram[int'(bus_if.vr_addr[i*AW +: AW])] : '0;
          end
          pend_push = 1;
          pend_data = mon_d;
          req_rd_cnt++;
          outst++;
        end
      end
      if (bus_if.wr_valid && bus_if.wr_ready) pend_wpop = 1;
      if (bus_if.vr_rvalid && bus_if.vr_rready) begin
        pend_rpop = 1;
        outst--;
      end
      if (bus_if.rd_valid && bus_if.rd_ready) begin
        rd_beats++;
        check("rd_expected", exp_rd.size() != 0, 1'b1);
        if (exp_rd.size() != 0) begin
          mon_r = exp_rd.pop_front();
          check("rd_data", bus_if.rd_data, mon_r.data);
          check("rd_last", bus_if.rd_last, mon_r.last);
        end
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, r0, b0, n0, v0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_base  = '0;
    bus_if.cmd_len   = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          {bus_if.cmd_ready, busy, done, bus_if.vr_valid, bus_if.wr_ready,
           bus_if.rd_valid, bus_if.rd_last, bus_if.vr_rready, bus_if.vr_write}, 9'b1_0000_0000);
    rst_n = 1'b1;
    tick();

    // Write 3 beats at 0x10 with no stalls.
    send_cmd(1'b1, 16'h0010, 3);
    wait_done(d);
    check("wr_done_latency", d - last_wr_cyc, 1);
    check("wr_lane_addr_beat2", last_wr_addr, 64'h001B_001A_0019_0018);
    tick();
    check("idle_after_done", {bus_if.cmd_ready, done, busy}, 3'b100);

    // Read back the same 3 beats.
    b0 = rd_beats; n0 = done_cnt;
    send_cmd(1'b0, 16'h0010, 3);
    wait_done(d);
    tick();
    check("rd3_beats", rd_beats - b0, 3);
    check("rd3_done_pulses", done_cnt - n0, 1);
    check("rd3_queue_empty", exp_rd.size(), 0);

    // Stray read return while idle must be dropped.
    inj_rvalid = 1'b1;
    #1;
    check("idle_rvalid_dropped", {bus_if.rd_valid, bus_if.vr_rready}, 2'b00);
    inj_rvalid = 1'b0;
    tick();

    // Random-stall write and read of 20 beats at 0x100.
    rand_vr = 1; rand_rd = 1; rand_wr = 1;
    send_cmd(1'b1, 16'h0100, 20);
    wait_done(d);
    tick();
    b0 = rd_beats;
    send_cmd(1'b0, 16'h0100, 20);
    wait_done(d);
    tick();
    check("rand_rd_beats", rd_beats - b0, 20);
    rand_vr = 0; rand_rd = 0; rand_wr = 0;
    tick();

    // Read consumer held off: issue must stop at the outstanding limit.
    rd_hold = 1;
    tick();
    r0 = req_rd_cnt; b0 = rd_beats;
    send_cmd(1'b0, 16'h0100, 20);
    repeat (30) tick();
    check("stall_issued", req_rd_cnt - r0, MO);
    check("stall_vr_valid_low", bus_if.vr_valid, 1'b0);
    check("stall_busy_no_cmd", {busy, bus_if.cmd_ready}, 2'b10);
    check("stall_no_returns", rd_beats - b0, 0);
    rd_hold = 0;
    wait_done(d);
    tick();
    check("stall_rd_beats", rd_beats - b0, 20);
    check("stall_queue_empty", exp_rd.size(), 0);

    // Zero-length commands complete without any RAM request.
    v0 = vr_valid_cnt;
    send_cmd(1'b0, 16'h0040, 0);
    check("len0_rd_done", done, 1'b1);
    tick();
    check("len0_rd_ready_again", bus_if.cmd_ready, 1'b1);
    send_cmd(1'b1, 16'h0040, 0);
    check("len0_wr_done", done, 1'b1);
    tick();
    check("len0_no_vr_valid", vr_valid_cnt - v0, 0);

    // Address wrap at the top of the element space.
    send_cmd(1'b1, 16'hFFFE, 1);
    wait_done(d);
    check("wrap_lane_addrs", last_wr_addr, 64'h0001_0000_FFFF_FFFE);
    tick();
    send_cmd(1'b0, 16'hFFFE, 1);
    wait_done(d);
    tick();

    // Reset in the middle of a stalled read, then a clean short read.
    rand_vr = 1; rand_rd = 1; rand_wr = 1;
    send_cmd(1'b0, 16'h0100, 20);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_outputs",
          {bus_if.cmd_ready, busy, done, bus_if.vr_valid, bus_if.wr_ready,
           bus_if.rd_valid, bus_if.rd_last, bus_if.vr_rready, bus_if.vr_write}, 9'b1_0000_0000);
    tick();
    exp_req.delete();
    exp_rd.delete();
    rst_n = 1'b1;
    tick();
    b0 = rd_beats; n0 = done_cnt;
    send_cmd(1'b0, 16'h0010, 2);
    wait_done(d);
    tick();
    check("post_reset_rd_beats", rd_beats - b0, 2);
    check("post_reset_done", done_cnt - n0, 1);
    check("post_reset_queue_empty", exp_rd.size(), 0);

    check("max_outstanding", max_outst, MO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_ram_stream_ctrl.md
Name: vector_ram_stream_ctrl

Overview:
Command-driven sequencer that sweeps a contiguous region of a vector RAM. It issues PARALLELISM-wide address beats to the RAM request interface. Write commands take beats from an input stream and write them; read commands issue read beats and stream the returned data out, with a bounded number of reads in flight. It sits between the SpMV/loader control logic and the vector RAM slave port.

Parameters:
PARALLELISM, 4, lanes per beat (power of 2)
DATA_WIDTH, 32, element width
ADDR_WIDTH, 16, element address width
LEN_WIDTH, 16, width of beat count
MAX_OUTSTANDING, 8, max read beats issued but not yet returned (≥1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write sweep, 0=read sweep
cmd_base  in  ADDR_WIDTH  element address of lane 0, beat 0
cmd_len  in  LEN_WIDTH  number of beats
wr_valid  in  1  write-stream beat valid
wr_ready  out  1  write-stream beat accepted
wr_data  in  PARALLELISM*DATA_WIDTH  lane i at bits [i*DW +: DW]
rd_valid  out  1  read-stream beat valid
rd_ready  in  1  read-stream consumer ready
rd_data  out  PARALLELISM*DATA_WIDTH  returned beat
rd_last  out  1  final beat of the command
vr_valid  out  1  RAM request valid
vr_ready  in  1  RAM request accepted
vr_write  out  1  RAM request is a write
vr_addr  out  PARALLELISM*ADDR_WIDTH  per-lane element addresses
vr_wdata  out  PARALLELISM*DATA_WIDTH  per-lane write data
vr_rvalid  in  1  RAM read beat returned (all lanes)
vr_rdata  in  PARALLELISM*DATA_WIDTH  RAM read data
vr_rready  out  1  RAM read beat consumed
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse on command completion

Behaviour:
- Reset: state=IDLE; all counters 0; outputs cmd_ready=1, busy=0, done=0, vr_valid=0, wr_ready=0, rd_valid=0, rd_last=0, vr_rready=0, vr_write=0.
- States: IDLE, WRITE, READ, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch base/len/write and clear issue_cnt, ret_cnt, outstanding. If len=0, go to DONE. Otherwise go to WRITE or READ. Command acceptance costs one cycle; the first vr_valid is possible on the next cycle.
- Lane address for beat b: vr_addr[i] = base + b*PARALLELISM + i, truncated mod 2^ADDR_WIDTH. Wrap-around is silent.
- WRITE: vr_valid=wr_valid; wr_ready=vr_ready; vr_write=1; vr_wdata=wr_data, combinational pass-through. A beat is transferred when wr_valid&vr_ready, and issue_cnt increments. When the beat with issue_cnt=len-1 transfers, go to DONE.
- READ issue side: vr_valid=1 when issue_cnt<len and outstanding<MAX_OUTSTANDING; vr_write=0. On vr_valid&vr_ready: issue_cnt++, outstanding++.
- READ return side: rd_valid=vr_rvalid; vr_rready=rd_ready; rd_data=vr_rdata. On vr_rvalid&rd_ready: ret_cnt++, outstanding--. rd_last=rd_valid&(ret_cnt=len-1).
- Simultaneous issue and return in one cycle: outstanding is unchanged.
- READ exits to DONE when the return with ret_cnt=len-1 completes. Issue has necessarily finished by then.
- vr_rvalid outside READ is a protocol error. It is dropped with vr_rready=0 and ignored.
- DONE: done=1 for exactly one cycle, cmd_ready=0, then IDLE. A back-to-back command can be accepted on the cycle after DONE.
- cmd_ready=0 in WRITE, READ and DONE. cmd_valid there is not accepted.
- Outputs vr_valid and rd_valid must not depend combinationally on vr_ready or rd_ready respectively.
- Reset mid-command: abandons the sweep immediately and returns to reset values. Read data in flight in the RAM after reset is ignored.
- Counter widths: issue_cnt and ret_cnt LEN_WIDTH; outstanding $clog2(MAX_OUTSTANDING+1).

Test Plan:
- Write base=0x10, len=3, wr_valid always high, vr_ready always high → three beats with lane-0 addresses 0x10, 0x14, 0x18 (PARALLELISM=4); done 1 cycle after the third beat; cmd_ready high the following cycle.
- Read base=0x10, len=3 after the write, RAM with 1-cycle latency, rd_ready=1 → rd_data matches the written beats in order; rd_last on beat 3 only; one done pulse.
- Read len=20, MAX_OUTSTANDING=8, rd_ready held low for 30 cycles → exactly 8 beats issued, vr_valid then low; after release all 20 beats return in order, outstanding never exceeds 8.
- cmd_len=0 (read and write) → no vr_valid; done pulses 1 cycle after acceptance.
- Base=0xFFFE, ADDR_WIDTH=16, len=1 write → vr_addr lanes 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Random vr_ready/rd_ready/wr_valid stalls, then rst_n asserted mid-read → all outputs at reset values the next cycle; a subsequent len=2 read completes normally with exactly 2 rd beats.
